ps2_led_cmd_ctrl: RTL and testbench
===================================

Name: ps2_led_cmd_ctrl

Overview:
- Host-to-device command sequencer for the PS/2 keyboard line.
- On request, sends the LED command pair: 0xED, then {5'b0, led_val}. Each byte is followed by a wait for the keyboard's 0xFA acknowledge, with resend and timeout retries.
- Owns the open-collector drive of ps2_clk/ps2_dat while active.
- Asserts busy so the scan-code decoder ignores frames it did not expect.
- Instantiated next to the keyboard decoder. rx_code/rx_valid come from the decoder's frame output.

Parameters:
- INHIBIT_CYC, 5000: clk cycles ps2_clk is held low before the start bit (100 us at 50 MHz).
- TIMEOUT_CYC, 1000000: per-byte watchdog, from INHIBIT entry to 0xFA receipt (20 ms at 50 MHz).
- MAX_RETRY, 3: timeout retries per byte before err.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous, active-low reset.
- ps2_clk_i, in, 1: PS/2 clock line, raw and asynchronous.
- ps2_dat_i, in, 1: PS/2 data line, raw and asynchronous.
- ps2_clk_oe, out, 1: 1 = pull ps2_clk low.
- ps2_dat_oe, out, 1: 1 = pull ps2_dat low.
- led_req, in, 1: one-cycle request to send LEDs.
- led_val, in, 3: {caps, num, scroll}.
- rx_code, in, 8: byte received by the decoder.
- rx_valid, in, 1: one-cycle strobe qualifying rx_code.
- busy, out, 1: sequence in progress (gates the decoder).
- done, out, 1: one-cycle pulse on successful completion.
- err, out, 1: one-cycle pulse on abort.

Behaviour:
- Reset: all outputs are 0 and asynchronously released (oe=0), including mid-transfer. The FSM goes to IDLE; the pending flag and retry count are cleared.
- Input sync:
  - ps2_clk_i and ps2_dat_i each pass through 3 flops.
  - fall = sync_prev & ~sync_now on the clock line, after synchronisation.
- Request capture:
  - led_req in IDLE starts a sequence the next cycle; led_val is latched into the byte1 register at that edge.
  - led_req while busy sets pending. When the current sequence finishes (done or err), a new sequence starts the next cycle using led_val at that time.
- FSM states: IDLE, INHIBIT, START, TX, LACK, WAIT_ACK, NEXT.
  - IDLE: busy=0. On start: byte_sel=0, retry=0, go to INHIBIT.
  - INHIBIT: clk_oe=1, dat_oe=0 for INHIBIT_CYC cycles. Then dat_oe=1 (start bit) and go to START.
  - START: clk_oe=0 (released), dat_oe=1. Wait for the first fall, then go to TX with bit index 0.
  - TX: on each fall, drive the next bit; dat_oe = ~bit.
    - Bits 0..7 of the current byte go out LSB first, then the parity bit, then stop (dat_oe=0).
    - Parity is odd: p = ~^byte. For 0xED, p=1. For 0x07, p=0.
    - After the stop bit is driven, go to LACK.
  - LACK: on the next fall, sample ps2_dat_sync.
    - 0: line ack OK, go to WAIT_ACK.
    - 1: treated as a timeout event.
  - WAIT_ACK: on rx_valid:
    - 0xFA: go to NEXT.
    - 0xFE: resend the same byte, going to INHIBIT. retry is not incremented.
    - Any other code: ignored.
  - NEXT:
    - If byte_sel=0: byte_sel=1, retry=0, go to INHIBIT.
    - Otherwise: pulse done, go to IDLE.
- Watchdog:
  - Counter clears on INHIBIT entry and runs in every non-IDLE state.
  - On reaching TIMEOUT_CYC: release both lines.
    - If retry < MAX_RETRY: retry++, go to INHIBIT, same byte.
    - Otherwise: pulse err, go to IDLE.
  - Resend via 0xFE is unlimited but still bounded by the watchdog on each attempt.
- busy=1 in every state except IDLE. done and err are never asserted in the same cycle.
- rx_valid arriving outside WAIT_ACK is ignored.
- If led_req and a completion occur in the same cycle, pending is set and honoured.

Decomposition:
- Package kbd_pkg holds:
  - the state enum;
  - constants KBD_CMD_LED=8'hED, KBD_ACK=8'hFA, KBD_RESEND=8'hFE;
  - the odd-parity function.
- Sub-module ps2_line_sync: 3-flop sync for both lines, plus the fall-detect output.

Test Plan (bench: INHIBIT_CYC=20, TIMEOUT_CYC=3000, MAX_RETRY=2; device model clocks at 40 clk/half-period):
- Nominal: led_req with led_val=3'b101.
  - clk_oe low exactly 20 cycles.
  - Model receives 0xED (parity 1), then 0x05 (parity 1); model ACKs 0xFA for each.
  - done pulses once; busy 0 the cycle after.
- Resend: model replies 0xFE to the first 0xED.
  - 0xED is sent again, then 0x05.
  - done pulses, err never pulses.
- Timeout: model is silent after the first INHIBIT.
  - 3 attempts start (initial + 2 retries), each after 3000 cycles.
  - err pulses once; both oe=0.
- Coalesce: led_req(3'b001) then led_req(3'b100) mid-transfer.
  - After the first done, a second sequence sends 0xED, 0x04.
- Reset mid-TX: drop reset_n during bit 4.
  - ps2_clk_oe and ps2_dat_oe go 0 asynchronously, before the next clk edge.
  - busy=0; no done or err.
- Line-ack missing: model leaves data high at the ack clock.
  - Retry is taken; the successful second attempt leads to done.

Source files
------------

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared state encoding, command bytes and parity helper for the PS/2 host sequencer.
package kbd_pkg;

   typedef logic [2:0] kbd_state_t;

   localparam kbd_state_t ST_IDLE     = 3'd0;
   localparam kbd_state_t ST_INHIBIT  = 3'd1;
   localparam kbd_state_t ST_START    = 3'd2;
   localparam kbd_state_t ST_TX       = 3'd3;
   localparam kbd_state_t ST_LACK     = 3'd4;
   localparam kbd_state_t ST_WAIT_ACK = 3'd5;
   localparam kbd_state_t ST_NEXT     = 3'd6;

   localparam logic [7:0] KBD_CMD_LED = 8'hED;
   localparam logic [7:0] KBD_ACK     = 8'hFA;
   localparam logic [7:0] KBD_RESEND  = 8'hFE;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 3-flop synchronisers for both PS/2 lines plus clock falling-edge detect.
module ps2_line_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic ps2_clk_i,
   input  logic ps2_dat_i,
   output logic dat_sync_o,
   output logic clk_fall_o
);

   logic [2:0] clk_q, dat_q;
   logic       clk_prev_q;

   // Idle lines float high, so reset to 1 to avoid a spurious fall after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_q      <= 3'b111;
         dat_q      <= 3'b111;
         clk_prev_q <= 1'b1;
      end else begin
         clk_q      <= {clk_q[1:0], ps2_clk_i};
         dat_q      <= {dat_q[1:0], ps2_dat_i};
         clk_prev_q <= clk_q[2];
      end
   end

   assign dat_sync_o = dat_q[2];
   assign clk_fall_o = clk_prev_q & ~clk_q[2];

endmodule

// File: rtl/ps2_led_cmd_ctrl.sv
// ps2_led_cmd_ctrl: sends the 0xED/LED command pair to a PS/2 keyboard,
// waiting for 0xFA after each byte with resend and watchdog retries.
module ps2_led_cmd_ctrl
   import kbd_pkg::*;
#(
   parameter int unsigned INHIBIT_CYC = 5000,
   parameter int unsigned TIMEOUT_CYC = 1000000,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   input  logic       led_req,
   input  logic [2:0] led_val,
   input  logic [7:0] rx_code,
   input  logic       rx_valid,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned RT_W = $clog2(MAX_RETRY + 2);
   localparam logic [WD_W-1:0] INH_LAST = WD_W'(INHIBIT_CYC - 1);
   localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [RT_W-1:0] RT_MAX   = RT_W'(MAX_RETRY);

   kbd_state_t      state_q, state_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic [RT_W-1:0] retry_q, retry_d;
   logic [3:0]      idx_q, idx_d;
   logic [2:0]      led_q, led_d;
   logic            sel_q, sel_d;
   logic            pend_q, pend_d;

   logic       dat_sync, clk_fall;
   logic [7:0] cur_byte;
   logic       tx_bit, tmo, fail, start, enter_inh, done_c, err_c;

   ps2_line_sync u_sync (
      .clk        (clk),
      .reset_n    (reset_n),
      .ps2_clk_i  (ps2_clk_i),
      .ps2_dat_i  (ps2_dat_i),
      .dat_sync_o (dat_sync),
      .clk_fall_o (clk_fall)
   );

   assign cur_byte = sel_q ? {5'b0, led_q} : KBD_CMD_LED;
   assign tx_bit   = idx_q[3] ? odd_parity(cur_byte) : cur_byte[idx_q[2:0]];
   assign tmo      = (state_q != ST_IDLE) && (wd_q == WD_LAST);
   // A missing line-level ack is handled exactly like a watchdog expiry.
   assign fail     = tmo | ((state_q == ST_LACK) & clk_fall & dat_sync);
   assign start    = (state_q == ST_IDLE) & (led_req | pend_q);

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      retry_d = retry_q;
      idx_d   = idx_q;
      led_d   = led_q;
      done_c  = 1'b0;
      err_c   = 1'b0;
      if (fail) begin
         if (retry_q < RT_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_INHIBIT;
         end else begin
            err_c   = 1'b1;
            state_d = ST_IDLE;
         end
      end else begin
         case (state_q)
            ST_IDLE: if (start) begin
               led_d   = led_val;
               sel_d   = 1'b0;
               retry_d = '0;
               state_d = ST_INHIBIT;
            end
            ST_INHIBIT: if (wd_q == INH_LAST) state_d = ST_START;
            ST_START: if (clk_fall) begin
               idx_d   = 4'd0;
               state_d = ST_TX;
            end
            ST_TX: if (clk_fall) begin
               if (idx_q == 4'd8) state_d = ST_LACK;
               else idx_d = idx_q + 4'd1;
            end
            ST_LACK: if (clk_fall) state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: if (rx_valid) begin
               if (rx_code == KBD_ACK) state_d = ST_NEXT;
               else if (rx_code == KBD_RESEND) state_d = ST_INHIBIT;
            end
            ST_NEXT: if (!sel_q) begin
               sel_d   = 1'b1;
               retry_d = '0;
               state_d = ST_INHIBIT;
            end else begin
               done_c  = 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign enter_inh = (state_d == ST_INHIBIT) && ((state_q != ST_INHIBIT) || fail);
   assign wd_d      = enter_inh ? '0 : busy ? wd_q + 1'b1 : '0;
   assign pend_d    = start ? 1'b0 : pend_q | (led_req & (state_q != ST_IDLE));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         wd_q    <= '0;
         retry_q <= '0;
         idx_q   <= '0;
         led_q   <= '0;
         sel_q   <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
         retry_q <= retry_d;
         idx_q   <= idx_d;
         led_q   <= led_d;
         sel_q   <= sel_d;
         pend_q  <= pend_d;
      end
   end

   // Outputs decode registered state only, so the async reset releases the lines at once.
   assign busy       = state_q != ST_IDLE;
   assign ps2_clk_oe = (state_q == ST_INHIBIT) & ~tmo;
   assign ps2_dat_oe = ~tmo & ((state_q == ST_START) | ((state_q == ST_TX) & ~tx_bit));
   assign done       = done_c;
   assign err        = err_c;

endmodule

// File: tb/tb_ps2_led_cmd_ctrl.sv
// tb_ps2_led_cmd_ctrl: directed/randomised bench with a behavioural PS/2 keyboard
// that clocks frames out of the host and answers like the scan-code decoder.
module tb_ps2_led_cmd_ctrl;

   localparam int INH  = 20;
   localparam int TMO  = 3000;
   localparam int RET  = 2;
   localparam int HALF = 40;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ps2_clk_oe, ps2_dat_oe, busy, done, err;
   logic       led_req = 1'b0;
   logic [2:0] led_val = '0;
   logic [7:0] rx_code = '0;
   logic       rx_valid = 1'b0;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;
   logic       clk_line, dat_line;

   int checks = 0, errors = 0, cyc = 0;
   int done_cnt = 0, err_cnt = 0, inh_len = 0, last_inh_len = 0;
   int inh_starts[$];
   logic [7:0] exp_q[$];
   logic oe_prev = 1'b0, done_prev = 1'b0;

   assign clk_line = ~(ps2_clk_oe | dev_clk_low);
   assign dat_line = ~(ps2_dat_oe | dev_dat_low);

   ps2_led_cmd_ctrl #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .MAX_RETRY(RET)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ps2_clk_i  (clk_line),
      .ps2_dat_i  (dat_line),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe),
      .led_req    (led_req),
      .led_val    (led_val),
      .rx_code    (rx_code),
      .rx_valid   (rx_valid),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor: inhibit pulse lengths/start times, done/err pulse counts.
   always @(negedge clk) begin
      cyc++;
      if (ps2_clk_oe === 1'b1) begin
         if (!oe_prev) begin
            inh_starts.push_back(cyc);
            inh_len = 0;
         end
         inh_len++;
      end else if (oe_prev) last_inh_len = inh_len;
      oe_prev = (ps2_clk_oe === 1'b1);
      if (done_prev) chk("busy_after_done", busy, 0);
      if (done === 1'b1) done_cnt++;
      if (err === 1'b1) err_cnt++;
      if (done === 1'b1 || err === 1'b1) chk("done_err_exclusive", done & err, 0);
      done_prev = (done === 1'b1);
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic request(input logic [2:0] v);
      @(negedge clk);
      led_val = v;
      led_req = 1'b1;
      @(negedge clk);
      led_req = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] c);
      @(negedge clk);
      rx_code  = c;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic expect_seq(input logic [2:0] v);
      exp_q.push_back(8'hED);
      exp_q.push_back({5'b0, v});
   endtask

   // Keyboard side of one host-to-device frame; abort_k>0 stops with clock held low at that pulse.
   task automatic recv(input bit skip_inh, input bit lack, input int abort_k,
                       output logic [7:0] b, output logic p, output logic s);
      logic [10:0] bits;
      bits = 'x;
      b = 'x;
      p = 1'bx;
      s = 1'bx;
      if (!skip_inh) begin
         for (int i = 0; i < 4000 && ps2_clk_oe !== 1'b1; i++) @(negedge clk);
         chk("inhibit_seen", ps2_clk_oe, 1);
      end
      for (int i = 0; i < 100 && ps2_clk_oe !== 1'b0; i++) @(negedge clk);
      chk("start_bit", ps2_dat_oe, 1);
      cycles(10);
      chk("inhibit_len", last_inh_len, INH);
      for (int k = 1; k <= 11; k++) begin
         dev_clk_low = 1'b1;
         if (k == abort_k) begin
            cycles(20);
            return;
         end
         cycles(HALF);
         dev_clk_low = 1'b0;
         bits[k-1] = dat_line;
         if (k == 10) dev_dat_low = lack;
         if (k == 11) dev_dat_low = 1'b0;
         cycles(HALF);
      end
      b = bits[7:0];
      p = bits[8];
      s = bits[9];
   endtask

   task automatic frame(input bit skip_inh, input bit lack);
      logic [7:0] b, e;
      logic p, s;
      recv(skip_inh, lack, 0, b, p, s);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 'x;
      chk("frame_byte", b, e);
      chk("odd_parity", 32'($countones({b, p}) % 2), 1);
      chk("stop_bit", s, 1);
   endtask

   task automatic wait_done(input string tag);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < 300 && done_cnt == d0; i++) @(negedge clk);
      chk(tag, done_cnt - d0, 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      logic [2:0] v;
      logic [7:0] junk, b;
      logic p, s;
      int d0, e0;

      cycles(3);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_clk_oe", ps2_clk_oe, 0);
      chk("rst_dat_oe", ps2_dat_oe, 0);
      reset_n = 1'b1;
      cycles(3);

      // Nominal 3'b101; an 0xFA during INHIBIT must be ignored.
      request(3'b101);
      expect_seq(3'b101);
      send_rx(8'hFA);
      chk("busy_nominal", busy, 1);
      frame(0, 1);
      send_rx(8'hFA);
      frame(0, 1);
      send_rx(8'hFA);
      wait_done("done_nominal");

      for (int n = 0; n < 2; n++) begin
         v = 3'($urandom_range(0, 7));
         request(v);
         expect_seq(v);
         frame(0, 1);
         send_rx(8'hFA);
         frame(0, 1);
         send_rx(8'hFA);
         wait_done("done_random");
      end

      // Resend: stray code ignored, then 0xFE repeats 0xED.
      v = 3'($urandom_range(0, 7));
      junk = 8'($urandom_range(0, 8'hE0));
      e0 = err_cnt;
      request(v);
      exp_q.push_back(8'hED);
      expect_seq(v);
      frame(0, 1);
      send_rx(junk);
      cycles(5);
      send_rx(8'hFE);
      frame(0, 1);
      send_rx(8'hFA);
      frame(0, 1);
      send_rx(8'hFA);
      wait_done("done_resend");
      chk("no_err_resend", err_cnt - e0, 0);

      // Silent keyboard: initial attempt plus RET retries, then err.
      inh_starts.delete();
      e0 = err_cnt;
      d0 = done_cnt;
      request(3'($urandom_range(0, 7)));
      for (int i = 0; i < 4 * TMO && err_cnt == e0; i++) @(negedge clk);
      chk("err_timeout", err_cnt - e0, 1);
      cycles(2);
      chk("attempts", inh_starts.size(), RET + 1);
      for (int i = 1; i < inh_starts.size(); i++)
         chk("retry_spacing", inh_starts[i] - inh_starts[i-1], TMO);
      chk("tmo_clk_oe", ps2_clk_oe, 0);
      chk("tmo_dat_oe", ps2_dat_oe, 0);
      chk("tmo_busy", busy, 0);
      chk("tmo_no_done", done_cnt - d0, 0);

      // Coalesce: second request while busy runs after the first completes.
      request(3'b001);
      expect_seq(3'b001);
      expect_seq(3'b100);
      frame(0, 1);
      request(3'b100);
      send_rx(8'hFA);
      frame(0, 1);
      send_rx(8'hFA);
      wait_done("done_coalesce_1");
      frame(0, 1);
      send_rx(8'hFA);
      frame(0, 1);
      send_rx(8'hFA);
      wait_done("done_coalesce_2");

      // Reset while bit 4 of 0xED (a 0) is being driven.
      d0 = done_cnt;
      e0 = err_cnt;
      request(3'($urandom_range(0, 7)));
      recv(0, 1, 5, b, p, s);
      chk("bit4_driven", ps2_dat_oe, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("async_clk_oe", ps2_clk_oe, 0);
      chk("async_dat_oe", ps2_dat_oe, 0);
      chk("async_busy", busy, 0);
      dev_clk_low = 1'b0;
      cycles(3);
      reset_n = 1'b1;
      cycles(5);
      chk("rst_mid_no_done", done_cnt - d0, 0);
      chk("rst_mid_no_err", err_cnt - e0, 0);
      chk("rst_mid_idle", busy, 0);

      // Missing line ack forces a retry of the same byte.
      v = 3'($urandom_range(0, 7));
      e0 = err_cnt;
      request(v);
      exp_q.push_back(8'hED);
      expect_seq(v);
      frame(0, 0);
      frame(1, 1);
      send_rx(8'hFA);
      frame(0, 1);
      send_rx(8'hFA);
      wait_done("done_lack_retry");
      chk("no_err_lack", err_cnt - e0, 0);
      chk("queue_drained", exp_q.size(), 0);

      cycles(5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
